key_debounce: RTL

//   Input-side counterpart to the LED driver. Samples KEY_W active-low push buttons
//   (pio_key), synchronises and debounces each one, and reports clean per-key events
//   to user logic: level, press pulse, release pulse and long-press pulse.

---
 rtl/key_debounce.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// key_debounce
//   Per-key synchroniser, debouncer and long-press detector for active-low
//   push buttons. Each key has its own FSM and counters and produces clean
//   level, press, release and long-press indications for the control logic.
//
// Ports
//   clk          in   1      system clock
//   rst          in   1      asynchronous active-high reset
//   pio_key      in   KEY_W  raw button pins, 0 = pressed, asynchronous to clk
//   key_level    out  KEY_W  debounced state, 1 = pressed
//   key_press    out  KEY_W  1-cycle pulse when a press is accepted
//   key_release  out  KEY_W  1-cycle pulse when a release is accepted
//   key_long     out  KEY_W  1-cycle pulse, once per press, at the hold threshold
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | key released and stable
// PRESS_F | key seen pressed, waiting out the debounce window
// HELD    | press accepted, key stable pressed
// REL_F   | key seen released while held, waiting out the debounce window

module key_debounce #(
  parameter int unsigned KEY_W    = 4,
  parameter int unsigned DEB_CNT  = 1_000_000 - 1,
  parameter int unsigned LONG_CNT = 50_000_000 - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] pio_key,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS_F = 2'd1,
    ST_HELD    = 2'd2,
    ST_REL_F   = 2'd3
  } state_t;

  for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
    logic [1:0]  r_sync;
    state_t      r_state;
    logic [31:0] r_deb_cnt;
    logic [31:0] r_hold_cnt;
    logic        r_long_done;
    logic        r_level;
    logic        r_press;
    logic        r_release;
    logic        r_long;

    logic        w_sync;
    logic        w_deb_done;
    logic        w_hold_run;
    logic        w_hold_hit;
    logic        w_rel_accept;

    // Two-flop synchroniser; inverted so 1 means pressed, resets to released.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync <= 2'b00;
      end else begin
        r_sync <= {r_sync[0], ~pio_key[gi]};
      end
    end

    assign w_sync       = r_sync[1];
    assign w_deb_done   = (r_deb_cnt == DEB_CNT);
    assign w_hold_run   = (r_state == ST_HELD) || (r_state == ST_REL_F);
    assign w_hold_hit   = w_hold_run && !r_long_done && (r_hold_cnt == LONG_CNT);
    assign w_rel_accept = (r_state == ST_REL_F) && !w_sync && w_deb_done;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state     <= ST_IDLE;
        r_deb_cnt   <= 32'd0;
        r_hold_cnt  <= 32'd0;
        r_long_done <= 1'b0;
        r_level     <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_long      <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        // A release accepted on the threshold cycle wins; the press is over
        // so a long-press event would be meaningless.
        r_long    <= w_hold_hit && !w_rel_accept;

        // Hold counter saturates at the threshold; the done flag keeps the
        // long pulse to a single cycle per press.
        if (w_hold_run && !r_long_done) begin
          if (r_hold_cnt == LONG_CNT) begin
            r_long_done <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
          end
        end

        case (r_state)
          ST_IDLE: begin
            if (w_sync) begin
              r_state   <= ST_PRESS_F;
              r_deb_cnt <= 32'd0;
            end
          end
          ST_PRESS_F: begin
            if (!w_sync) begin
              r_state <= ST_IDLE;
            end else if (w_deb_done) begin
              r_state     <= ST_HELD;
              r_press     <= 1'b1;
              r_level     <= 1'b1;
              r_hold_cnt  <= 32'd0;
              r_long_done <= 1'b0;
            end else begin
              r_deb_cnt <= r_deb_cnt + 32'd1;
            end
          end
          ST_HELD: begin
            if (!w_sync) begin
              r_state   <= ST_REL_F;
              r_deb_cnt <= 32'd0;
            end
          end
          ST_REL_F: begin
            // Bounce back to HELD leaves the hold counter running.
            if (w_sync) begin
              r_state <= ST_HELD;
            end else if (w_deb_done) begin
              r_state   <= ST_IDLE;
              r_release <= 1'b1;
              r_level   <= 1'b0;
            end else begin
              r_deb_cnt <= r_deb_cnt + 32'd1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end

    assign key_level[gi]   = r_level;
    assign key_press[gi]   = r_press;
    assign key_release[gi] = r_release;
    assign key_long[gi]    = r_long;
  end

endmodule
